tile_occupancy_map: RTL and testbench

Receiving end of the pixel-plot stream (`plot`/`x`/`y`/`colour`) that our drawing FSMs emit toward the VGA adapter. It mirrors the 160x120 framebuffer at 10x10-tile granularity (16x12 = 192 tiles, 3-bit colour each). Game logic can then query what occupies any tile (snake body, apple, empty) for collision and apple-eaten detection. It sits in parallel with the VGA adapter on the same plot bus; the game controller is the query requester.

---
 rtl/tile_map_pkg.sv | 35 +++
 rtl/tile_ram.sv | 32 +++
 rtl/tile_occupancy_map.sv | 182 ++++++++++++++++++
 tb/tb_tile_occupancy_map.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_map_pkg.sv
// tile_map_pkg: shared constants, FSM state type and pixel-to-tile helper
// for the tile occupancy map. Screen is 160x120 pixels mirrored as a
// 16x12 grid of 10x10 tiles, 3-bit colour per tile.
package tile_map_pkg;

    localparam int unsigned XSCREEN = 160;
    localparam int unsigned YSCREEN = 120;
    localparam int unsigned TILE    = 10;
    localparam int unsigned COLS    = XSCREEN / TILE;
    localparam int unsigned ROWS    = YSCREEN / TILE;
    localparam int unsigned NTILES  = COLS * ROWS;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned CLR_W   = 3;
    localparam int unsigned CRD_W   = 4;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        READ,
        ACK,
        HOLD
    } state_t;

    // Pixel coordinate to tile coordinate: a ladder of constant compares
    // against multiples of TILE, so no divider is built.
    function automatic logic [CRD_W-1:0] tile_of(input logic [7:0] p);
        logic [CRD_W-1:0] t;
        t = '0;
        for (int unsigned k = 1; k < COLS; k++) begin
            if (p >= 8'(k * TILE)) t = CRD_W'(k);
        end
        return t;
    endfunction

endpackage

// File: rtl/tile_ram.sv
// tile_ram: 192x3 simple dual-port RAM, one write port and one registered
// read port. A read and write of the same address on one edge returns the
// old contents. No reset, so it maps onto block or LUT RAM.
// Ports:
//   clk    - clock
//   we     - write enable; waddr/wdata written at the edge
//   waddr  - write tile index
//   wdata  - write colour
//   re     - read enable; rdata updated at the edge
//   raddr  - read tile index
//   rdata  - registered read colour
module tile_ram
    import tile_map_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [CLR_W-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [CLR_W-1:0] rdata
);

    logic [CLR_W-1:0] mem [NTILES];

    // Both ports in one block: the read samples mem before the write lands.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/tile_occupancy_map.sv
// tile_occupancy_map: snoops the pixel plot bus and keeps the last colour
// drawn into each 10x10 tile, so game logic can ask what occupies a tile.
// Ports:
//   CLOCK_50      - system clock
//   reset         - asynchronous active-high reset; restarts the clear sweep
//   plot, x, y    - pixel write strobe and coordinates
//   colour        - pixel colour, 0 = background
//   clear         - pulse requesting a full-map clear sweep
//   busy          - high while the clear sweep runs (plots dropped)
//   q_req         - query request level, held until q_ack
//   q_col, q_row  - queried tile
//   q_ack         - one-cycle response strobe
//   q_colour      - stored colour of the queried tile
//   q_hit         - tile occupied (colour != 0, or off-map row)
module tile_occupancy_map
    import tile_map_pkg::*;
(
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             plot,
    input  logic [7:0]       x,
    input  logic [6:0]       y,
    input  logic [CLR_W-1:0] colour,
    input  logic             clear,
    output logic             busy,
    input  logic             q_req,
    input  logic [CRD_W-1:0] q_col,
    input  logic [CRD_W-1:0] q_row,
    output logic             q_ack,
    output logic [CLR_W-1:0] q_colour,
    output logic             q_hit
);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] sweep_idx, sweep_nxt;
    logic             clr_pend, pend_nxt;
    logic [IDX_W-1:0] q_idx, q_idx_nxt;
    logic             q_wall, wall_nxt;
    logic             busy_nxt;
    logic             q_ack_nxt;
    logic [CLR_W-1:0] q_colour_nxt;
    logic             q_hit_nxt;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CLR_W-1:0] wr_colour;

    logic             on_screen;
    logic [IDX_W-1:0] pix_idx;

    logic             ram_we;
    logic [IDX_W-1:0] ram_waddr;
    logic [CLR_W-1:0] ram_wdata;
    logic             ram_re;
    logic [CLR_W-1:0] rd_data;

    // Pixel to tile index; COLS is 16 so row*16+col is a plain concatenation.
    assign on_screen = (x < 8'(XSCREEN)) && (y < 7'(YSCREEN));
    assign pix_idx   = {tile_of({1'b0, y}), tile_of(x)};

    // Write stage: accepted plots are registered and land in the RAM next edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_en     <= 1'b0;
            wr_idx    <= '0;
            wr_colour <= '0;
        end else begin
            wr_en     <= plot && on_screen && !busy;
            wr_idx    <= pix_idx;
            wr_colour <= colour;
        end
    end

    // The sweep owns the write port; a plot registered just before a sweep
    // starts is discarded, which is harmless since the sweep zeroes it anyway.
    assign ram_we    = (state == CLEAR) || wr_en;
    assign ram_waddr = (state == CLEAR) ? sweep_idx : wr_idx;
    assign ram_wdata = (state == CLEAR) ? '0 : wr_colour;
    assign ram_re    = (state == READ) && !q_wall;

    tile_ram u_ram (
        .clk   (CLOCK_50),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (q_idx),
        .rdata (rd_data)
    );

    // FSM and output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= CLEAR;
            sweep_idx <= '0;
            clr_pend  <= 1'b0;
            q_idx     <= '0;
            q_wall    <= 1'b0;
            busy      <= 1'b1;
            q_ack     <= 1'b0;
            q_colour  <= '0;
            q_hit     <= 1'b0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= sweep_nxt;
            clr_pend  <= pend_nxt;
            q_idx     <= q_idx_nxt;
            q_wall    <= wall_nxt;
            busy      <= busy_nxt;
            q_ack     <= q_ack_nxt;
            q_colour  <= q_colour_nxt;
            q_hit     <= q_hit_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        sweep_nxt    = sweep_idx;
        pend_nxt     = clr_pend;
        q_idx_nxt    = q_idx;
        wall_nxt     = q_wall;
        q_ack_nxt    = 1'b0;
        q_colour_nxt = q_colour;
        q_hit_nxt    = q_hit;

        case (state)
            CLEAR: begin
                // A clear pulse during the sweep is ignored.
                pend_nxt  = 1'b0;
                sweep_nxt = sweep_idx + IDX_W'(1);
                if (sweep_idx == IDX_W'(NTILES - 1)) begin
                    state_nxt = IDLE;
                    sweep_nxt = '0;
                end
            end
            IDLE: begin
                if (q_req) begin
                    q_idx_nxt = {q_row, q_col};
                    // Every 4-bit column is on the map; only rows 12..15 are off it.
                    wall_nxt  = (q_row >= CRD_W'(ROWS));
                    pend_nxt  = clear;
                    state_nxt = READ;
                end else if (clear) begin
                    sweep_nxt = '0;
                    state_nxt = CLEAR;
                end
            end
            READ: begin
                pend_nxt  = clr_pend || clear;
                state_nxt = ACK;
            end
            ACK: begin
                pend_nxt     = clr_pend || clear;
                q_ack_nxt    = 1'b1;
                q_colour_nxt = q_wall ? '0 : rd_data;
                q_hit_nxt    = q_wall || (rd_data != '0);
                state_nxt    = HOLD;
            end
            HOLD: begin
                // Wait for the requester to drop q_req so one request is served once.
                pend_nxt = clr_pend || clear;
                if (!q_req) begin
                    if (clr_pend || clear) begin
                        pend_nxt  = 1'b0;
                        sweep_nxt = '0;
                        state_nxt = CLEAR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                sweep_nxt = '0;
                state_nxt = CLEAR;
            end
        endcase

        busy_nxt = (state_nxt == CLEAR);
    end

endmodule

// File: tb/tb_tile_occupancy_map.sv
// Testbench for tile_occupancy_map: random plots and queries against a
// 12x16 tile-array model; expected query responses are queued when a query
// is issued and checked by a monitor whenever q_ack is seen.
module tb_tile_occupancy_map;

    logic       CLOCK_50;
    logic       reset;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       clear;
    logic       busy;
    logic       q_req;
    logic [3:0] q_col;
    logic [3:0] q_row;
    logic       q_ack;
    logic [2:0] q_colour;
    logic       q_hit;

    tile_occupancy_map dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .plot     (plot),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .clear    (clear),
        .busy     (busy),
        .q_req    (q_req),
        .q_col    (q_col),
        .q_row    (q_row),
        .q_ack    (q_ack),
        .q_colour (q_colour),
        .q_hit    (q_hit)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int colour;
        int hit;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   model [12][16];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   ack_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: off-map rows are a wall; otherwise the last colour drawn.
    function automatic exp_t exp_of(input int col, input int row, input string name);
        exp_t e;
        e.name = name;
        if (col >= 16 || row >= 12) begin
            e.colour = 0;
            e.hit    = 1;
        end else begin
            e.colour = model[row][col];
            e.hit    = (model[row][col] != 0) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 16; c++)
                model[r][c] = 0;
    endtask

    // Scoreboard monitor.
    always @(negedge CLOCK_50) begin
        if (!reset && q_ack) begin
            exp_t e;
            ack_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_ack: got ack with colour %0d hit %0d, expected none", q_colour, q_hit);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_colour"}, int'(q_colour), e.colour);
                check({e.name, "_hit"}, int'(q_hit), e.hit);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_plot(input int px, input int py, input int pc);
        @(posedge CLOCK_50); #1;
        plot = 1'b1; x = 8'(px); y = 7'(py); colour = 3'(pc);
        @(posedge CLOCK_50); #1;
        plot = 1'b0;
        if (px < 160 && py < 120) model[py / 10][px / 10] = pc;
    endtask

    task automatic pulse_clear();
        @(posedge CLOCK_50); #1;
        clear = 1'b1;
        @(posedge CLOCK_50); #1;
        clear = 1'b0;
    endtask

    // Wait for the next ack; lat counts posedges until it is visible.
    task automatic wait_ack(input int a0, input bit clr_in_read, output int lat);
        lat = 0;
        while (ack_cnt == a0 && lat < 40) begin
            @(posedge CLOCK_50); lat++; #1;
            clear = clr_in_read && (lat == 1);
            @(negedge CLOCK_50); #1;
        end
        clear = 1'b0;
        if (ack_cnt == a0) check("ack_timeout", 0, 1);
    endtask

    task automatic do_query(input int col, input int row, input int hold_extra,
                            input bit clr_in_read, input string name);
        int lat;
        int a0;
        exp_q.push_back(exp_of(col, row, name));
        @(posedge CLOCK_50); #1;
        q_col = 4'(col); q_row = 4'(row); q_req = 1'b1;
        a0 = ack_cnt;
        wait_ack(a0, clr_in_read, lat);
        check({name, "_latency"}, lat, 3);
        repeat (hold_extra) @(negedge CLOCK_50);
        q_req = 1'b0;
        @(posedge CLOCK_50); #1;
    endtask

    // Count edges until busy falls; optionally poke the DUT mid-sweep.
    task automatic count_busy(input int inject, output int bc);
        bc = 0;
        x = 8'd5; y = 7'd5; colour = 3'd6;
        while (busy && bc < 400) begin
            @(posedge CLOCK_50); #1; bc++;
            plot  = (inject == 1) && (bc == 100);
            clear = (inject == 2) && (bc == 100);
        end
        plot = 1'b0; clear = 1'b0;
    endtask

    initial begin
        int bc;
        int lat;
        int a0;
        reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0; clear = 1'b0;
        q_req = 1'b1; q_col = '0; q_row = '0;
        model_clear();

        // Reset state, then the power-up sweep with q_req held high.
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50); #1;
        check("rst_busy", int'(busy), 1);
        check("rst_q_ack", int'(q_ack), 0);
        check("rst_q_colour", int'(q_colour), 0);
        check("rst_q_hit", int'(q_hit), 0);
        exp_q.push_back(exp_of(0, 0, "first_ack"));
        @(negedge CLOCK_50);
        reset = 1'b0;
        #1;
        count_busy(0, bc);
        check("reset_sweep_cycles", bc, 192);
        check("acks_during_sweep", ack_cnt, 0);
        wait_ack(0, 1'b0, lat);
        check("first_ack_latency", lat, 3);
        q_req = 1'b0;
        @(posedge CLOCK_50); #1;

        // Write, erase and dropped off-screen plot.
        do_plot(25, 35, 4);
        do_query(2, 3, 0, 1'b0, "write");
        do_plot(29, 39, 0);
        do_query(2, 3, 0, 1'b0, "erase");
        do_plot(160, 50, 7);
        do_query(15, 5, 0, 1'b0, "offscreen_x");
        do_plot(159, 119, 3);
        do_query(15, 11, 0, 1'b0, "corner");

        // Wall queries; a long-held request yields exactly one ack.
        a0 = ack_cnt;
        do_query(3, 12, 10, 1'b0, "wall_hold");
        check("wall_hold_ack_count", ack_cnt - a0, 1);
        do_query(15, 15, 0, 1'b0, "wall_max");

        // Randomised plots and queries.
        for (int i = 0; i < 40; i++) begin
            int px, py, n;
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                px = $urandom_range(0, 199);
                py = $urandom_range(0, 127);
                do_plot(px, py, $urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 1 && px < 160 && py < 120)
                do_query(px / 10, py / 10, $urandom_range(0, 2), 1'b0, "rand_hit");
            else
                do_query($urandom_range(0, 15), $urandom_range(0, 14), $urandom_range(0, 2), 1'b0, "rand");
        end

        // Same-edge write and read of tile (5,5): old value, then new value.
        do_plot(55, 55, 2);
        exp_q.push_back(exp_of(5, 5, "hazard_old"));
        @(posedge CLOCK_50); #1;
        plot = 1'b1; x = 8'd55; y = 7'd55; colour = 3'd5;
        q_col = 4'd5; q_row = 4'd5; q_req = 1'b1;
        a0 = ack_cnt;
        @(posedge CLOCK_50); #1;
        plot = 1'b0;
        model[5][5] = 5;
        wait_ack(a0, 1'b0, lat);
        check("hazard_latency", lat, 2);
        q_req = 1'b0;
        @(posedge CLOCK_50); #1;
        do_query(5, 5, 0, 1'b0, "hazard_new");

        // Clear pulse while in READ: ack carries pre-clear data, then a sweep.
        do_plot(25, 35, 6);
        do_query(2, 3, 0, 1'b1, "clear_in_read");
        check("clear_after_query_busy", int'(busy), 1);
        count_busy(2, bc);
        check("clear_sweep_cycles", bc, 192);
        model_clear();
        do_query(2, 3, 0, 1'b0, "cleared_a");
        do_query(5, 5, 0, 1'b0, "cleared_b");
        do_query(15, 11, 0, 1'b0, "cleared_c");

        // Reset in the middle of a sweep restarts it from index 0.
        do_plot(0, 0, 3);
        do_plot(155, 115, 7);
        do_plot(77, 88, 1);
        do_query(15, 11, 0, 1'b0, "pre_reset");
        pulse_clear();
        check("idle_clear_busy", int'(busy), 1);
        repeat (50) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 1);
        check("midrst_q_colour", int'(q_colour), 0);
        check("midrst_q_hit", int'(q_hit), 0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        #1;
        count_busy(1, bc);
        check("midrst_sweep_cycles", bc, 192);
        model_clear();
        do_query(0, 0, 0, 1'b0, "post_rst_a");
        do_query(15, 11, 0, 1'b0, "post_rst_b");
        do_query(7, 8, 0, 1'b0, "post_rst_c");
        do_query(0, 12, 0, 1'b0, "post_rst_wall");

        repeat (4) @(posedge CLOCK_50);
        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
